mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the pipeline.
- Sequences each access over a fixed memory latency.
- Drives per-requester stalls toward the hazard logic.
- Discards in-flight fetches on a branch flush.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
LATENCY, 2, cycles from ram_en cycle to ram_rdata valid; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  branch flush pulse; cancels a pending fetch result
if_req  in  1  fetch request, held until if_ack or flush
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetched word, valid while if_ack=1
stall_if  out  1  fetch stage must hold
mem_rd  in  1  data read request
mem_wr  in  1  data write request
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  write data
mem_ack  out  1  one-cycle pulse, data access complete
mem_rdata  out  DATA_W  read word, valid while mem_ack=1
stall_mem  out  1  memory stage must hold
ram_en  out  1  memory access strobe
ram_we  out  1  memory write enable
ram_addr  out  ADDR_W  memory address
ram_wdata  out  DATA_W  memory write data
ram_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, any state): state=IDLE. ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0. if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0. drop flag=0. last_grant=IF, so MEM wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE. Grant is IF or MEM.
- IDLE: samples requests at the rising edge.
  - Only one requester active: grant it.
  - Both active: grant the requester other than last_grant (round-robin).
  - Move to ISSUE and latch grant, address, write-enable and write data.
- ISSUE: held for exactly one cycle.
  - ram_en=1. ram_we=1 only for a MEM write.
  - Load wait counter with LATENCY, then go to WAIT.
- WAIT: counter decrements each cycle.
  - On the cycle the counter reads 1, capture ram_rdata into the granted requester's rdata register and go to DONE.
  - Writes follow identical timing and return no data.
- DONE: held for one cycle.
  - Pulse the granted requester's ack (if_ack suppressed if drop=1).
  - Update last_grant, clear drop, go to IDLE.
  - Requests are not sampled in DONE; the requester deasserts after its ack.
- Latency: request sampled at edge N, ack high in cycle N+LATENCY+2. Minimum spacing between accesses is LATENCY+3 cycles.
- ram_en, ram_we, ram_addr and ram_wdata are registered. ram_en and ram_we are 0 outside ISSUE; ram_addr and ram_wdata hold their last value.
- Stalls are combinational:
  - stall_if = if_req and not if_ack.
  - stall_mem = (mem_rd or mem_wr) and not mem_ack.
- Flush:
  - flush=1 while the grant is IF in ISSUE, WAIT or DONE: drop=1, and if_ack is not asserted for that access.
  - The memory access still completes its timing; the FSM is not shortened.
  - Flush in IDLE, or during a MEM grant: no effect.
  - Flush coincident with IDLE sampling if_req: the request is not granted that edge.
- mem_rd and mem_wr both high: treated as a write.
- if_rdata and mem_rdata hold their value between acks.
- Reset mid-access: the access is abandoned, no ack is issued, and ram_en deasserts immediately.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - grant encoding (GRANT_IF=0, GRANT_MEM=1)
  - LATENCY range constants
- One sub-module, mem_wait_counter:
  - load/decrement counter, 4 bits wide
  - outputs a last-cycle flag
  - async active-high reset
- All arbitration, flush handling and datapath registers stay in mem_port_arbiter.

Test Plan:
- Reset, then if_req=1, if_addr=0x10, ram_rdata=0xA5 during the capture cycle (LATENCY=2) -> ram_en high exactly one cycle with ram_addr=0x10, ram_we=0. if_ack pulses at N+4 with if_rdata=0xA5. stall_if=1 until that cycle.
- mem_wr=1, mem_addr=0x22, mem_wdata=0x3C -> one ISSUE cycle with ram_en=1, ram_we=1, ram_addr=0x22, ram_wdata=0x3C. mem_ack at N+4. mem_rdata unchanged.
- if_req and mem_rd asserted together, both held across accesses -> MEM granted first, then IF. Swap the roles on the next pair -> grants alternate, with no starvation over 10 accesses.
- if_req at 0x40, flush pulse in the second WAIT cycle -> ram_en still issued, no if_ack, if_rdata keeps its previous value, FSM back in IDLE at N+5.
- flush during a MEM read of 0x05, ram_rdata=0x77 -> mem_ack and mem_rdata=0x77 unaffected.
- reset asserted mid-WAIT -> all outputs 0 asynchronously. After release, a fresh mem_rd completes with normal N+4 latency.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Load/decrement counter timing the memory latency window.
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last_c = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and
// memory stages, with fixed-latency sequencing and fetch flush handling.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall_if,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            r_grant;
    grant_t            w_grant_nxt;
    grant_t            r_last_grant;
    logic              r_wr;
    logic              r_drop;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_if_req;
    logic w_mem_req;
    logic w_start;
    logic w_flush_hit;
    logic w_capture;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_last_c;

    // A flush in the same cycle as a fetch request blocks that grant.
    assign w_if_req    = if_req & ~flush;
    assign w_mem_req   = mem_rd | mem_wr;
    assign w_start     = (r_state == IDLE) && (w_state_nxt == ISSUE);
    assign w_flush_hit = flush && (r_grant == GRANT_IF) && (r_state != IDLE);
    assign w_capture   = (r_state == WAIT) && w_last_c;
    assign w_cnt_load  = (r_state == ISSUE);
    assign w_cnt_dec   = (r_state == WAIT);

    mem_wait_counter u_wait_cnt (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LD),
        .i_dec      (w_cnt_dec),
        .o_last_c   (w_last_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (w_if_req && w_mem_req) begin
                    w_grant_nxt = (r_last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
                    w_state_nxt = ISSUE;
                end else if (w_if_req) begin
                    w_grant_nxt = GRANT_IF;
                    w_state_nxt = ISSUE;
                end else if (w_mem_req) begin
                    w_grant_nxt = GRANT_MEM;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_last_c) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant      <= GRANT_IF;
            r_last_grant <= GRANT_IF;
            r_wr         <= 1'b0;
            r_drop       <= 1'b0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_ram_en  <= w_start;
            r_ram_we  <= w_start && (w_grant_nxt == GRANT_MEM) && mem_wr;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;

            if (w_start) begin
                r_grant <= w_grant_nxt;
                if (w_grant_nxt == GRANT_MEM) begin
                    r_wr        <= mem_wr;
                    r_ram_addr  <= mem_addr;
                    r_ram_wdata <= mem_wdata;
                end else begin
                    r_wr        <= 1'b0;
                    r_ram_addr  <= if_addr;
                end
            end

            // Dropped fetches still run full timing but never update if_rdata.
            if (w_capture) begin
                if (r_grant == GRANT_MEM) begin
                    r_mem_ack <= 1'b1;
                    if (!r_wr) r_mem_rdata <= ram_rdata;
                end else if (!r_drop && !flush) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= ram_rdata;
                end
            end

            if (r_state == DONE) begin
                r_last_grant <= r_grant;
                r_drop       <= 1'b0;
            end else if (w_flush_hit) begin
                r_drop <= 1'b1;
            end
        end
    end

    // A flush arriving in DONE still cancels the fetch ack that cycle.
    assign if_ack    = r_if_ack & ~flush;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = (mem_rd | mem_wr) & ~mem_ack;

endmodule
